// File: rtl/clk_div_gen.sv
`default_nettype none
// ============================================================================
// clk_div_gen : multi-channel programmable clock divider (period/high/phase)
// Rev 1.0
// ============================================================================
module clk_div_gen #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   enable,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   running
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // Clamped write values are shared by all channels; only the target latches them.
  logic [CNT_W-1:0] wr_period;
  logic [CNT_W-1:0] wr_high;

  always_comb begin
    wr_period = (cfg_period < CNT_W'(2)) ? CNT_W'(2) : cfg_period;
    wr_high   = (cfg_high == '0) ? CNT_W'(1) : cfg_high;
    if (wr_high >= wr_period) begin
      wr_high = wr_period - CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] dcnt_q,     dcnt_d;
    logic [CNT_W-1:0] sh_per_q,   sh_per_d;
    logic [CNT_W-1:0] sh_high_q,  sh_high_d;
    logic [CNT_W-1:0] sh_ph_q,    sh_ph_d;
    logic [CNT_W-1:0] act_per_q,  act_per_d;
    logic [CNT_W-1:0] act_high_q, act_high_d;
    logic             clk_out_q,  clk_out_d;
    logic             wr;
    logic             wrap;

    assign wr   = cfg_we && (cfg_sel == SEL_W'(i));
    assign wrap = (cnt_q == act_per_q - CNT_W'(1));

    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dcnt_d     = dcnt_q;
      clk_out_d  = clk_out_q;
      sh_per_d   = sh_per_q;
      sh_high_d  = sh_high_q;
      sh_ph_d    = sh_ph_q;
      act_per_d  = act_per_q;
      act_high_d = act_high_q;

      if (wr) begin
        sh_per_d  = wr_period;
        sh_high_d = wr_high;
        sh_ph_d   = cfg_phase;
      end

      case (state_q)
        S_IDLE: begin
          act_per_d  = sh_per_q;
          act_high_d = sh_high_q;
          cnt_d      = '0;
          clk_out_d  = 1'b0;
          if (enable[i]) begin
            if (sh_ph_q == '0) begin
              state_d = S_RUN;
            end else begin
              state_d = S_DELAY;
              dcnt_d  = sh_ph_q - CNT_W'(1);
            end
          end
        end
        S_DELAY: begin
          if (!enable[i]) begin
            state_d = S_IDLE;
          end else if (dcnt_q == '0) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            dcnt_d = dcnt_q - CNT_W'(1);
          end
        end
        S_RUN, S_DRAIN: begin
          // Output lags the counter by one edge so cnt=0 is the first high cycle.
          clk_out_d = (cnt_q < act_high_q);
          cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
          if (wrap) begin
            act_per_d  = sh_per_q;
            act_high_d = sh_high_q;
          end
          if (enable[i]) begin
            state_d = S_RUN;
          end else if ((state_q == S_DRAIN) && wrap) begin
            state_d   = S_IDLE;
            clk_out_d = 1'b0;
          end else begin
            state_d = S_DRAIN;
          end
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= S_IDLE;
        cnt_q      <= '0;
        dcnt_q     <= '0;
        clk_out_q  <= 1'b0;
        sh_per_q   <= CNT_W'(2);
        sh_high_q  <= CNT_W'(1);
        sh_ph_q    <= '0;
        act_per_q  <= CNT_W'(2);
        act_high_q <= CNT_W'(1);
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        dcnt_q     <= dcnt_d;
        clk_out_q  <= clk_out_d;
        sh_per_q   <= sh_per_d;
        sh_high_q  <= sh_high_d;
        sh_ph_q    <= sh_ph_d;
        act_per_q  <= act_per_d;
        act_high_q <= act_high_d;
      end
    end

    assign clk_out[i] = clk_out_q;
    assign running[i] = (state_q != S_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_gen.sv
`default_nettype none
// ============================================================================
// tb_clk_div_gen : randomized bench for clk_div_gen against a timing-rule model
// Rev 1.0
// ============================================================================
module tb_clk_div_gen;

  localparam int NCH   = 3;
  localparam int CNT_W = 8;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NCH-1:0]   enable = '0;
  logic             cfg_we = 1'b0;
  logic [SEL_W-1:0] cfg_sel = '0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic [CNT_W-1:0] cfg_high = '0;
  logic [CNT_W-1:0] cfg_phase = '0;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   running;

  int n_tests = 0;
  int n_fail  = 0;
  int ecount  = 0;

  // Reference model: each channel is a waveform in absolute edge time.
  int m_act  [NCH];
  int m_gen  [NCH];
  int m_rise [NCH];
  int m_pos  [NCH];
  int m_cper [NCH];
  int m_chi  [NCH];
  int m_nper [NCH];
  int m_nhi  [NCH];
  int m_prev [NCH];
  int sh_per [NCH];
  int sh_hi  [NCH];
  int sh_ph  [NCH];
  logic [NCH-1:0] exp_clk;
  logic [NCH-1:0] exp_run;

  clk_div_gen #(.NCH(NCH), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_phase  (cfg_phase),
    .clk_out    (clk_out),
    .running    (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, ecount, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_act[c] = 0; m_gen[c] = 0; m_rise[c] = 0; m_pos[c] = 0;
      m_cper[c] = 2; m_chi[c] = 1; m_nper[c] = 2; m_nhi[c] = 1; m_prev[c] = 0;
      sh_per[c] = 2; sh_hi[c] = 1; sh_ph[c] = 0;
    end
    exp_clk = '0;
    exp_run = '0;
  endtask

  task automatic model_edge();
    int e;
    int p;
    int h;
    ecount++;
    for (int c = 0; c < NCH; c++) begin
      e = int'(enable[c]);
      if (m_act[c] == 0) begin
        if (e != 0) begin
          m_act[c]  = 1;
          m_gen[c]  = 0;
          m_rise[c] = ecount + 1 + sh_ph[c];
          m_cper[c] = sh_per[c];
          m_chi[c]  = sh_hi[c];
        end
      end else if (m_gen[c] == 0) begin
        if (ecount == m_rise[c]) begin
          m_gen[c] = 1;
          m_pos[c] = 0;
        end else if (e == 0) begin
          m_act[c] = 0;
        end
      end else begin
        m_pos[c]++;
        if (m_pos[c] == m_cper[c]) begin
          m_pos[c]  = 0;
          m_cper[c] = m_nper[c];
          m_chi[c]  = m_nhi[c];
        end
        // Last cycle of a period: next period's config is fixed and a stop may land.
        if (m_pos[c] == m_cper[c] - 1) begin
          m_nper[c] = sh_per[c];
          m_nhi[c]  = sh_hi[c];
          if (e == 0 && m_prev[c] == 0) begin
            m_act[c] = 0;
            m_gen[c] = 0;
          end
        end
      end
      m_prev[c]  = e;
      exp_run[c] = (m_act[c] != 0);
      exp_clk[c] = (m_act[c] != 0) && (m_gen[c] != 0) && (m_pos[c] < m_chi[c]);
    end
    if (cfg_we && int'(cfg_sel) < NCH) begin
      p = int'(cfg_period);
      if (p < 2) p = 2;
      h = int'(cfg_high);
      if (h == 0) h = 1;
      if (h >= p) h = p - 1;
      sh_per[int'(cfg_sel)] = p;
      sh_hi[int'(cfg_sel)]  = h;
      sh_ph[int'(cfg_sel)]  = int'(cfg_phase);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("clk_out[%0d]", c), 32'(clk_out[c]), 32'(exp_clk[c]));
      check($sformatf("running[%0d]", c), 32'(running[c]), 32'(exp_run[c]));
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic wr(input int sel, input int per, input int hi, input int ph);
    cfg_we     = 1'b1;
    cfg_sel    = SEL_W'(sel);
    cfg_period = CNT_W'(per);
    cfg_high   = CNT_W'(hi);
    cfg_phase  = CNT_W'(ph);
    cyc();
    cfg_we     = 1'b0;
  endtask

  initial begin
    int k;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_clk_out", 32'(clk_out), 32'(0));
    check("reset_running", 32'(running), 32'(0));
    rst_n = 1'b1;

    // Basic 4/2 waveform on ch0
    wr(0, 4, 2, 0);
    enable[0] = 1'b1;
    run(12);

    // Phase offset between ch0 and ch1 with equal period
    enable = '0;
    run(20);
    wr(0, 10, 3, 0);
    wr(1, 10, 3, 5);
    enable[1:0] = 2'b11;
    run(210);

    // Graceful stop, then re-raise during drain
    enable = '0;
    run(20);
    wr(0, 8, 4, 0);
    enable[0] = 1'b1;
    run(2);
    enable[0] = 1'b0;
    run(12);
    enable[0] = 1'b1;
    run(5);
    enable[0] = 1'b0;
    run(3);
    enable[0] = 1'b1;
    run(20);

    // Clamping and out-of-range select
    wr(2, 1, 0, 0);
    enable[2] = 1'b1;
    run(10);
    wr(2, 5, 9, 0);
    run(20);
    wr(3, 6, 2, 1);
    run(10);

    // Config change mid-run lands at the next wrap
    enable[0] = 1'b0;
    run(12);
    wr(0, 6, 3, 0);
    enable[0] = 1'b1;
    run(8);
    wr(0, 4, 1, 0);
    run(30);

    // Short enable pulse during a long phase delay
    enable[1] = 1'b0;
    run(15);
    wr(1, 4, 2, 7);
    enable[1] = 1'b1;
    run(2);
    enable[1] = 1'b0;
    run(12);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 15) == 0) enable[c] = ~enable[c];
      end
      if ($urandom_range(0, 7) == 0) begin
        cfg_we     = 1'b1;
        cfg_sel    = SEL_W'($urandom_range(0, 3));
        cfg_period = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 1))
                                                 : CNT_W'($urandom_range(2, 12));
        cfg_high   = CNT_W'($urandom_range(0, 14));
        cfg_phase  = ($urandom_range(0, 19) == 0) ? CNT_W'($urandom_range(0, 40))
                                                  : CNT_W'($urandom_range(0, 9));
      end else begin
        cfg_we = 1'b0;
      end
      cyc();
    end
    cfg_we = 1'b0;

    // Asynchronous reset while a channel is high
    enable = '1;
    k = 0;
    while (clk_out == '0 && k < 300) begin
      cyc();
      k++;
    end
    check("pre_reset_high", 32'(clk_out != '0), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_clk_out", 32'(clk_out), 32'(0));
    check("async_rst_running", 32'(running), 32'(0));
    model_reset();
    #1 rst_n = 1'b1;
    run(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
